// File: rtl/uart_transmitter.sv
// Free-running 8N1 UART transmitter: frames and sends the byte on bus continuously.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_transmitter #(
   parameter int unsigned CLK_FREQ     = 100_000_000,
   parameter int unsigned BAUD         = 38400,
   parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] bus,
   output logic       tx
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_t;
`else
   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;
`endif

   state_t          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            tx_q, tx_d;
   logic            tick;

   assign tick = (cnt_q == CntMax);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
         case (state_q)
            StIdle: begin
               shreg_d = bus;
               state_d = StStart;
            end
            StStart: begin
               idx_d   = 3'd0;
               state_d = StData;
            end
            StData: begin
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            StParity: state_d = StStop;
`endif
            StStop: begin
               // Back-to-back frames: the next byte is latched straight into START.
               shreg_d = bus;
               state_d = StStart;
            end
            default: state_d = StIdle;
         endcase
      end

      // tx follows the next state so every bit is registered on its own boundary.
      case (state_d)
         StIdle:   tx_d = 1'b1;
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shreg_d[idx_d];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = ^shreg_d;
`endif
         StStop:   tx_d = 1'b1;
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shreg_q <= 8'h00;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
      end
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: frame-table vectors, directed corner cases,
// randomized bytes against a time-based frame model plus a mid-bit sampling receiver.
module tb_uart_transmitter;

   localparam int unsigned CLK_FREQ = 100_000_000;
   localparam int unsigned BAUD     = 12_500_000;
   localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif
   localparam int FRAME = CPB * FB;
   localparam int NT = 6;

   typedef struct {
      logic [7:0]  data;
      logic [10:0] exp;   // tx level per bit period, bit 0 = start bit
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] bus = 8'h00;
   logic       tx;

   uart_transmitter #(
      .CLK_FREQ(CLK_FREQ),
      .BAUD    (BAUD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .tx (tx)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference timeline: edges since reset and bytes present on bus at each frame capture.
   int         ecount = 0;
   int         cyc = 0;
   logic [7:0] cap[$];
   bit         model_en = 1'b0;

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         ecount = 0;
         cap.delete();
      end else begin
         ecount++;
         if (ecount >= CPB && (ecount - CPB) % FRAME == 0) cap.push_back(bus);
      end
   end

   function automatic logic model_tx(input int e);
      int p, f, b;
      if (e < CPB) return 1'b1;
      p = e / CPB - 1;
      f = p / FB;
      b = p % FB;
      if (f >= cap.size()) return 1'bx;
      if (b == 0) return 1'b0;
      if (b <= 8) return cap[f][b-1];
      if (FB == 11 && b == 9) return ^cap[f];
      return 1'b1;
   endfunction

   // Receiver model state
   bit         rx_busy = 1'b0;
   logic       rx_prev = 1'b1;
   int         rx_cnt = 0;
   int         rx_start = 0;
   bit         rx_bad = 1'b0;
   int         rx_ferr = 0;
   logic [7:0] rx_sh = 8'h00;
   logic [7:0] rx_q[$];
   int         rx_t[$];

   initial forever begin
      int b;
      @(posedge clk);
      #1;
      if (model_en) check("model_tx", 32'(tx), 32'(model_tx(ecount)));
      if (rst) begin
         rx_busy = 1'b0;
      end else if (rx_busy) begin
         rx_cnt++;
         if (rx_cnt % CPB == CPB / 2) begin
            b = rx_cnt / CPB;
            if (b == 0) begin
               if (tx !== 1'b0) rx_bad = 1'b1;
            end else if (b <= 8) begin
               rx_sh[b-1] = tx;
            end else if (b == FB - 1) begin
               if (tx !== 1'b1) rx_bad = 1'b1;
               rx_q.push_back(rx_sh);
               rx_t.push_back(rx_start);
               if (rx_bad) rx_ferr++;
               rx_busy = 1'b0;
            end else begin
               if (tx !== ^rx_sh) rx_bad = 1'b1;
            end
         end
      end else if (tx === 1'b0 && rx_prev === 1'b1) begin
         rx_busy  = 1'b1;
         rx_cnt   = 0;
         rx_bad   = 1'b0;
         rx_start = cyc;
      end
      rx_prev = tx;
   end

   task automatic wait_ec(input int n);
      int guard = 0;
      while (ecount < n && guard < 100000) begin
         @(negedge clk);
         guard++;
      end
      if (ecount != n) check("wait_ec", 32'(ecount), 32'(n));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rx_q.delete();
      rx_t.delete();
      rx_ferr = 0;
   endtask

   task automatic first_fall(input string name);
      int t = 0;
      while (tx === 1'b1 && t < 4 * CPB) begin
         @(negedge clk);
         t++;
      end
      check(name, 32'(ecount), 32'(CPB));
   endtask

   vec_t       tab[NT];
   logic [7:0] msg[13];
   bit         ok;
   int         cap_e;

   initial begin
`ifdef UART_TX_PARITY_EN
      tab[0] = '{8'h48, 11'h490};
      tab[1] = '{8'h49, 11'h692};
      tab[2] = '{8'h00, 11'h400};
      tab[3] = '{8'hFF, 11'h5FE};
      tab[4] = '{8'h01, 11'h602};
      tab[5] = '{8'h80, 11'h700};
`else
      tab[0] = '{8'h48, 11'h290};
      tab[1] = '{8'hA5, 11'h34A};
      tab[2] = '{8'hFF, 11'h3FE};
      tab[3] = '{8'h00, 11'h200};
      tab[4] = '{8'h01, 11'h202};
      tab[5] = '{8'h80, 11'h300};
`endif
      msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
              8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

      // Reset hold, then idle period before the first start bit
      rst = 1'b1;
      bus = 8'h00;
      repeat (3) @(negedge clk);
      model_en = 1'b1;
      ok = 1'b1;
      repeat (2000) begin
         @(negedge clk);
         if (tx !== 1'b1) ok = 1'b0;
      end
      check("reset_hold", 32'(ok), 32'd1);
      rst = 1'b0;
      first_fall("first_start_edge");

      // Frame table, with bus scrambled right after each capture
      do_reset();
      for (int i = 0; i < NT; i++) begin
         cap_e = CPB + i * FRAME;
         wait_ec(cap_e - 1);
         bus = tab[i].data;
         wait_ec(cap_e);
         bus = 8'($urandom);
         for (int j = 0; j < FB; j++) begin
            wait_ec(cap_e + j * CPB + CPB / 2);
            check($sformatf("tab%0d_bit%0d", i, j), 32'(tx), 32'(tab[i].exp[j]));
         end
      end

      // Bus change during data bit 3
      do_reset();
      wait_ec(CPB - 1);
      bus = 8'hA5;
      wait_ec(5 * CPB + 2);
      bus = 8'hFF;
      wait_ec(2 * CPB + 2 * FRAME);
      check("midchg_count", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() >= 2) begin
         check("midchg_byte0", 32'(rx_q[0]), 32'hA5);
         check("midchg_byte1", 32'(rx_q[1]), 32'hFF);
      end

      // One-cycle reset during data bit 4
      bus = 8'h00;
      do_reset();
      wait_ec(6 * CPB + CPB / 2);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_tx", 32'(tx), 32'd1);
      rst = 1'b0;
      check("rst_mid_partial", 32'(rx_q.size()), 32'd0);
      first_fall("rst_mid_restart");

      // String stream
      do_reset();
      for (int i = 0; i < 13; i++) begin
         wait_ec(CPB + i * FRAME - 1);
         bus = msg[i];
      end
      wait_ec(CPB + 13 * FRAME + 2);
      check("hello_count", 32'(rx_q.size()), 32'd13);
      check("hello_ferr", 32'(rx_ferr), 32'd0);
      if (rx_q.size() == 13) begin
         for (int i = 0; i < 13; i++) begin
            check($sformatf("hello_byte%0d", i), 32'(rx_q[i]), 32'(msg[i]));
            if (i > 0)
               check($sformatf("hello_gap%0d", i), 32'(rx_t[i] - rx_t[i-1]), 32'(FRAME));
         end
      end

      // Randomized bytes with random mid-frame bus noise
      do_reset();
      for (int i = 0; i < 30; i++) begin
         wait_ec(CPB + i * FRAME - 1);
         bus = 8'($urandom);
         wait_ec(CPB + i * FRAME + int'($urandom_range(1, FRAME - 2)));
         bus = 8'($urandom);
      end
      wait_ec(CPB + 30 * FRAME + 2);
      check("rand_count", 32'(rx_q.size()), 32'd30);
      check("rand_ferr", 32'(rx_ferr), 32'd0);
      if (rx_q.size() == 30 && cap.size() >= 30) begin
         for (int k = 0; k < 30; k++)
            check($sformatf("rand_byte%0d", k), 32'(rx_q[k]), 32'(cap[k]));
      end

      model_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
